// File: rtl/ntt_bf_scheduler.sv
// Address/zeta scheduler for the Dilithium NTT butterfly: walks LOG_N layers, issues reads,
// and replays them as write-backs D cycles later. Define NTT_SCHED_INV_EN for the inverse (GS) schedule.
module ntt_bf_scheduler #(
  parameter int N       = 256,
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1,
  parameter int BF_LAT  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
`ifdef NTT_SCHED_INV_EN
  input  logic              mode_i,
  output logic              zeta_neg_o,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr1_o,
  output logic [ADDR_W-1:0] rd_addr2_o,
  output logic [ADDR_W-1:0] zeta_addr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr1_o,
  output logic [ADDR_W-1:0] wr_addr2_o,
  output logic [2:0]        layer_o
);

  localparam int LOG_N = $clog2(N);
  localparam int D     = RAM_LAT + BF_LAT;
  localparam int BW    = LOG_N - 1;
  localparam int CW    = $clog2(D + 1);
  localparam int AW1   = ADDR_W + 1;

  localparam logic [BW-1:0] B_LAST     = BW'(N / 2 - 1);
  localparam logic [2:0]    LAYER_LAST = 3'(LOG_N - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(D - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     b_q, b_d;
  logic [2:0]        layer_q, layer_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mode_q, mode_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
  logic [ADDR_W-1:0] rd_addr2_q, rd_addr2_d;
  logic [ADDR_W-1:0] zeta_q, zeta_d;
  logic              zneg_q, zneg_d;

  logic              wr_en_pipe_q [D];
  logic              wr_en_pipe_d [D];
  logic [ADDR_W-1:0] wr_a1_pipe_q [D];
  logic [ADDR_W-1:0] wr_a1_pipe_d [D];
  logic [ADDR_W-1:0] wr_a2_pipe_q [D];
  logic [ADDR_W-1:0] wr_a2_pipe_d [D];

  logic [2:0]        sh;
  logic [ADDR_W-1:0] len_mask;
  logic [ADDR_W-1:0] b_ext;
  logic [ADDR_W-1:0] g;
  logic [ADDR_W-1:0] addr1;
  logic [AW1-1:0]    zeta_inv;
  logic              issue_d;

  // Next-state logic for the layer/butterfly walk.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    layer_d = layer_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          b_d     = '0;
          layer_d = '0;
`ifdef NTT_SCHED_INV_EN
          mode_d  = mode_i;
`else
          mode_d  = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (b_q == B_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          if (layer_q == LAYER_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            layer_d = layer_q + 3'd1;
            b_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses for the butterfly being issued next cycle; len is a power of two, so
  // b mod len and b / len are a mask and a shift, and 2*len*g is the high part shifted by one.
  always_comb begin
    sh       = mode_d ? layer_d : (3'(LOG_N - 1) - layer_d);
    len_mask = (ADDR_W'(1) << sh) - ADDR_W'(1);
    b_ext    = ADDR_W'(b_d);
    g        = b_ext >> sh;
    addr1    = ((b_ext & ~len_mask) << 1) | (b_ext & len_mask);
    zeta_inv = (AW1'(N) >> layer_d) - AW1'(1) - AW1'(g);
    issue_d  = (state_d == S_ISSUE);

    rd_en_d    = issue_d;
    rd_addr1_d = issue_d ? addr1 : '0;
    rd_addr2_d = issue_d ? (addr1 + len_mask + ADDR_W'(1)) : '0;
    zeta_d     = '0;
    if (issue_d) begin
      zeta_d = mode_d ? zeta_inv[ADDR_W-1:0] : ((ADDR_W'(1) << layer_d) + g);
    end
    zneg_d = issue_d & mode_d;
    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Write-back delay line: reads re-emerge D cycles later as writes.
  always_comb begin
    wr_en_pipe_d[0] = rd_en_q;
    wr_a1_pipe_d[0] = rd_addr1_q;
    wr_a2_pipe_d[0] = rd_addr2_q;
    for (int i = 1; i < D; i++) begin
      wr_en_pipe_d[i] = wr_en_pipe_q[i-1];
      wr_a1_pipe_d[i] = wr_a1_pipe_q[i-1];
      wr_a2_pipe_d[i] = wr_a2_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      b_q        <= '0;
      layer_q    <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      zeta_q     <= '0;
      zneg_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      layer_q    <= layer_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr1_q <= rd_addr1_d;
      rd_addr2_q <= rd_addr2_d;
      zeta_q     <= zeta_d;
      zneg_q     <= zneg_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < D; i++) begin
      if (reset_i) begin
        wr_en_pipe_q[i] <= 1'b0;
        wr_a1_pipe_q[i] <= '0;
        wr_a2_pipe_q[i] <= '0;
      end else begin
        wr_en_pipe_q[i] <= wr_en_pipe_d[i];
        wr_a1_pipe_q[i] <= wr_a1_pipe_d[i];
        wr_a2_pipe_q[i] <= wr_a2_pipe_d[i];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr1_o  = rd_addr1_q;
  assign rd_addr2_o  = rd_addr2_q;
  assign zeta_addr_o = zeta_q;
  assign wr_en_o     = wr_en_pipe_q[D-1];
  assign wr_addr1_o  = wr_a1_pipe_q[D-1];
  assign wr_addr2_o  = wr_a2_pipe_q[D-1];
  assign layer_o     = layer_q;
`ifdef NTT_SCHED_INV_EN
  assign zeta_neg_o  = zneg_q;
`else
  logic unused_zneg;
  assign unused_zneg = zneg_q;
`endif

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Bench for ntt_bf_scheduler: cycle-exact comparison against a per-cycle schedule table
// built from the layer/butterfly formulas, plus named spot checks of key cycles.
module tb_ntt_bf_scheduler;

  localparam int MAXC = 1100;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       busy_o, done_o, rd_en_o, wr_en_o;
  logic [7:0] rd_addr1_o, rd_addr2_o, zeta_addr_o, wr_addr1_o, wr_addr2_o;
  logic [2:0] layer_o;
`ifdef NTT_SCHED_INV_EN
  logic       mode_i;
  logic       zeta_neg_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference schedule, indexed by cycle number relative to the start cycle.
  bit         m_busy [0:MAXC];
  bit         m_done [0:MAXC];
  bit         m_rd   [0:MAXC];
  bit         m_wr   [0:MAXC];
  bit         m_zn   [0:MAXC];
  logic [7:0] m_a1   [0:MAXC];
  logic [7:0] m_a2   [0:MAXC];
  logic [7:0] m_z    [0:MAXC];
  logic [7:0] m_w1   [0:MAXC];
  logic [7:0] m_w2   [0:MAXC];
  logic [2:0] m_lay  [0:MAXC];

  ntt_bf_scheduler dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
`ifdef NTT_SCHED_INV_EN
    .mode_i      (mode_i),
    .zeta_neg_o  (zeta_neg_o),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr1_o  (rd_addr1_o),
    .rd_addr2_o  (rd_addr2_o),
    .zeta_addr_o (zeta_addr_o),
    .wr_en_o     (wr_en_o),
    .wr_addr1_o  (wr_addr1_o),
    .wr_addr2_o  (wr_addr2_o),
    .layer_o     (layer_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void build_model(input bit inv);
    int c, len, g, a1;
    for (int i = 0; i <= MAXC; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_rd[i] = 0; m_wr[i] = 0; m_zn[i] = 0;
      m_a1[i] = 0; m_a2[i] = 0; m_z[i] = 0; m_w1[i] = 0; m_w2[i] = 0; m_lay[i] = 0;
    end
    for (int l = 0; l < 8; l++) begin
      for (int k = 1; k <= 133; k++) begin
        m_busy[133*l + k] = 1;
        m_lay[133*l + k]  = 3'(l);
      end
      for (int b = 0; b < 128; b++) begin
        c   = 1 + 133*l + b;
        len = inv ? (1 << l) : (128 >> l);
        g   = b / len;
        a1  = 2*len*g + (b % len);
        m_rd[c] = 1;
        m_zn[c] = inv;
        m_a1[c] = 8'(a1);
        m_a2[c] = 8'(a1 + len);
        m_z[c]  = inv ? 8'((256 >> l) - 1 - g) : 8'((1 << l) + g);
        m_wr[c+5] = 1;
        m_w1[c+5] = 8'(a1);
        m_w2[c+5] = 8'(a1 + len);
      end
    end
    m_done[1065] = 1;
  endfunction

  function automatic logic [63:0] dut_vec();
    logic zn;
    zn = 1'b0;
`ifdef NTT_SCHED_INV_EN
    zn = zeta_neg_o;
`endif
    return {16'd0, zn, busy_o, done_o, rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o,
            wr_en_o, wr_addr1_o, wr_addr2_o, (busy_o ? layer_o : 3'd0)};
  endfunction

  function automatic logic [63:0] model_vec(input int c);
    logic zn;
    zn = 1'b0;
`ifdef NTT_SCHED_INV_EN
    zn = m_zn[c];
`endif
    return {16'd0, zn, m_busy[c], m_done[c], m_rd[c], m_a1[c], m_a2[c], m_z[c],
            m_wr[c], m_w1[c], m_w2[c], (m_busy[c] ? m_lay[c] : 3'd0)};
  endfunction

  task automatic spot_fwd(input int c);
    case (c)
      1:    check("l0_first",   {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o}, {1'b1, 8'd0, 8'd128, 8'd1});
      2:    check("l0_second",  {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o}, {1'b1, 8'd1, 8'd129, 8'd1});
      5:    check("wr_not_yet", wr_en_o, 0);
      6:    check("wr_first",   {wr_en_o, wr_addr1_o, wr_addr2_o}, {1'b1, 8'd0, 8'd128});
      128:  check("l0_last",    {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o}, {1'b1, 8'd127, 8'd255, 8'd1});
      131:  check("drain_rd",   {rd_en_o, busy_o, layer_o}, {1'b0, 1'b1, 3'd0});
      133:  check("l0_lastwr",  {wr_en_o, wr_addr1_o, wr_addr2_o, rd_en_o}, {1'b1, 8'd127, 8'd255, 1'b0});
      134:  check("l1_first",   {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o, layer_o}, {1'b1, 8'd0, 8'd64, 8'd2, 3'd1});
      932:  check("l7_first",   {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o}, {1'b1, 8'd0, 8'd1, 8'd128});
      933:  check("l7_second",  {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o}, {1'b1, 8'd2, 8'd3, 8'd129});
      1059: check("l7_last",    {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o}, {1'b1, 8'd254, 8'd255, 8'd255});
      1064: check("last_wr",    {wr_en_o, wr_addr1_o, wr_addr2_o, done_o}, {1'b1, 8'd254, 8'd255, 1'b0});
      1065: check("done_pulse", {done_o, busy_o, wr_en_o}, {1'b1, 1'b0, 1'b0});
      1066: check("done_once",  {done_o, busy_o}, {1'b0, 1'b0});
      default: ;
    endcase
  endtask

`ifdef NTT_SCHED_INV_EN
  task automatic spot_inv(input int c);
    case (c)
      1:   check("inv_first",  {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o, zeta_neg_o}, {1'b1, 8'd0, 8'd1, 8'd255, 1'b1});
      2:   check("inv_second", {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o, zeta_neg_o}, {1'b1, 8'd2, 8'd3, 8'd254, 1'b1});
      932: check("inv_l7",     {rd_en_o, rd_addr1_o, rd_addr2_o, zeta_addr_o, zeta_neg_o}, {1'b1, 8'd0, 8'd128, 8'd1, 1'b1});
      default: ;
    endcase
  endtask
`endif

  // One transform: start in cycle 0, compare every cycle 1..last_c. abort_at >= 0 asserts
  // reset during that cycle, after which every output must read zero.
  task automatic run(input bit inv, input int last_c, input int abort_at, input bit spot);
    build_model(inv);
    repeat ($urandom_range(1, 4)) @(negedge clk_i);
    check("idle_busy", {busy_o, rd_en_o, wr_en_o, done_o}, 4'b0000);
`ifdef NTT_SCHED_INV_EN
    mode_i = inv;
`endif
    start_i = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk_i);
      if (abort_at >= 0 && c > abort_at)
        check($sformatf("abort_cyc%0d", c), dut_vec(), 64'd0);
      else
        check($sformatf("cyc%0d", c), dut_vec(), model_vec(c));
      if (spot && !inv) spot_fwd(c);
`ifdef NTT_SCHED_INV_EN
      if (spot && inv) spot_inv(c);
      mode_i = 1'($urandom_range(0, 1));
`endif
      reset_i = (c == abort_at);
      if (abort_at >= 0 && c >= abort_at) start_i = 1'b0;
      else if (c <= 1065)                 start_i = (c == 50) || ($urandom_range(0, 3) == 0);
      else                                start_i = 1'b0;
    end
    start_i = 1'b0;
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
`ifdef NTT_SCHED_INV_EN
    mode_i  = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    check("rst_outputs", dut_vec(), 64'd0);
    check("rst_layer", layer_o, 3'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("idle_outputs", dut_vec(), 64'd0);

    run(1'b0, 1070, -1, 1'b1);
    run(1'b0, 310, 300, 1'b0);
    run(1'b0, 1070, -1, 1'b1);
`ifdef NTT_SCHED_INV_EN
    run(1'b1, 1070, -1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_bf_scheduler.md
Name: ntt_bf_scheduler

Overview:
- Upstream control stage for the Dilithium NTT butterfly datapath (Q = 8380417).
- Walks the 8-layer, 256-point Cooley-Tukey schedule and issues coefficient-pair read addresses and the zeta ROM index that feed the butterfly's data1/data2/zeta inputs.
- Issues the matching write-back addresses once the butterfly results emerge.
- Inserts per-layer drain gaps so that no layer reads a coefficient before the previous layer has written it.

Parameters:
- N, 256: polynomial length (power of two); LOG_N = log2(N) layers.
- ADDR_W, 8: coefficient RAM and zeta ROM address width.
- RAM_LAT, 1: coefficient RAM read latency, in cycles.
- BF_LAT, 4: butterfly pipeline latency, in cycles.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  start a transform; sampled only in IDLE.
- busy_o  out  1  high while issuing or draining.
- done_o  out  1  one-cycle pulse when the final write has completed.
- rd_en_o  out  1  read strobe for both RAM ports.
- rd_addr1_o  out  ADDR_W  index j, feeds data1.
- rd_addr2_o  out  ADDR_W  index j+len, feeds data2.
- zeta_addr_o  out  ADDR_W  zeta ROM index; valid with rd_en_o.
- wr_en_o  out  1  write-back strobe for both RAM ports.
- wr_addr1_o  out  ADDR_W  write-back address for data1_o.
- wr_addr2_o  out  ADDR_W  write-back address for data2_o.
- layer_o  out  3  current layer, 0..7.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-operation aborts immediately, clears the address delay line (no stale wr_en_o), and emits no done_o.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start_i=1 -> ISSUE with layer=0, b=0.
  - ISSUE: one butterfly per cycle, b = 0..N/2-1. After b = N/2-1, go to DRAIN.
  - DRAIN: rd_en_o=0 for D = RAM_LAT + BF_LAT cycles. Then go to ISSUE with layer+1, or to DONE if layer was LOG_N-1.
  - DONE: done_o=1 for one cycle, busy_o=0, then IDLE.
- Address generation, with len = (N/2) >> layer and g = b / len:
  - rd_addr1_o = 2*len*g + (b mod len).
  - rd_addr2_o = rd_addr1_o + len.
  - zeta_addr_o = (1 << layer) + g, covering 1..255 across the transform.
  - Use shifts and masks only; no dividers.
- Write-back: wr_en_o, wr_addr1_o and wr_addr2_o are rd_en_o, rd_addr1_o and rd_addr2_o delayed by exactly D cycles through a shift register.
- Hazard rule: the first read of layer L+1 occurs one cycle after the last write of layer L. This is safe for read-first RAM.
- busy_o is high from the first ISSUE cycle through the last DRAIN cycle.
- start_i is ignored while busy_o=1 or during DONE.
- layer_o updates on entry to ISSUE and holds through DRAIN.
- Timing with defaults (D=5), start_i high in cycle 0:
  - Layer L issues in cycles 1+133L .. 128+133L.
  - Last write is in cycle 1064; done_o is in cycle 1065.

Optional Feature:
- Macro NTT_SCHED_INV_EN.
- Defined:
  - Adds input mode_i (1 bit), latched on start; mode_i=1 selects the inverse (Gentleman-Sande) schedule.
  - Adds output zeta_neg_o (1 bit), high alongside rd_en_o in inverse mode.
  - Inverse schedule: len = 1 << layer; zeta_addr_o = (N >> layer) - 1 - g, so layer 0 runs 255..128 and layer 7 is 1.
  - Read and write addressing formulas are unchanged.
- Undefined: neither port exists and only the forward schedule is generated.

Test Plan:
- Reset: hold reset_i 3 cycles -> all outputs 0, FSM idle.
- Layer 0 pattern: start -> cycle 1 gives rd (0,128), zeta 1; cycle 2 gives (1,129), zeta 1; cycle 128 gives (127,255), zeta 1.
- Layer 7 pattern:
  - Cycle 932 gives rd (0,1), zeta 128.
  - Cycle 933 gives (2,3), zeta 129.
  - Cycle 1059 gives (254,255), zeta 255.
- Write-back and drain:
  - wr_en_o first high in cycle 6 with addresses (0,128).
  - rd_en_o low in cycles 129..133.
  - Last layer-0 write in cycle 133; layer-1 first read (0,64), zeta 2, in cycle 134.
  - done_o exactly in cycle 1065; busy_o low from 1065 on.
- Abort and restart:
  - start_i pulsed in cycle 50 is ignored.
  - reset_i in cycle 300 -> wr_en_o=0 from cycle 301, no done_o.
  - A subsequent start reproduces the layer-0 sequence from scratch.
- Inverse mode (NTT_SCHED_INV_EN, mode_i=1):
  - Cycle 1 gives rd (0,1), zeta 255, zeta_neg_o=1.
  - Cycle 2 gives (2,3), zeta 254.
  - Layer 7 first issue gives (0,128), zeta 1.
